pong_game_ctrl: RTL

Game-level sequencer for the Pong ball datapath. It owns the ball position registers, which feed the ball update block's old_x/old_y. Once per frame it checks the position for wall, paddle and miss conditions and drives the ball block's touching_paddle/touching_wall/reset inputs. It captures the stepped position, keeps the score and runs serve and game-over sequencing.

---
 rtl/pong_game_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns the ball position, classifies wall/paddle/miss once per
// frame, drives the ball block's control inputs and runs scoring, serve and game-over flow.
module pong_game_ctrl #(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int STEP        = 10,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_LX   = 20,
    parameter int PADDLE_RX   = 620,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           serve_btn,
    input  logic           pause,
    input  logic [Y_W-1:0] paddle_l_y,
    input  logic [Y_W-1:0] paddle_r_y,
    input  logic [X_W-1:0] ball_new_x,
    input  logic [Y_W-1:0] ball_new_y,
    output logic [X_W-1:0] ball_pos_x,
    output logic [Y_W-1:0] ball_pos_y,
    output logic           ball_rst,
    output logic           touching_paddle,
    output logic           touching_wall,
    output logic [3:0]     score_l,
    output logic [3:0]     score_r,
    output logic           game_over
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SERVE   = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_POINT   = 3'd6;
    localparam logic [2:0] S_OVER    = 3'd7;

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [X_W-1:0]   CENTRE_X = X_W'(SCREEN_W / 2);
    localparam logic [Y_W-1:0]   CENTRE_Y = Y_W'(SCREEN_H / 2);
    localparam logic [X_W-1:0]   X_LIMIT  = X_W'(SCREEN_W);
    localparam logic [X_W-1:0]   LEFT_X   = X_W'(PADDLE_LX);
    localparam logic [X_W-1:0]   RIGHT_X  = X_W'(PADDLE_RX);
    localparam logic [Y_W-1:0]   WALL_LO  = Y_W'(STEP);
    localparam logic [Y_W-1:0]   WALL_HI  = Y_W'(SCREEN_H - 1 - STEP);
    localparam logic [Y_W:0]     PAD_SPAN = (Y_W + 1)'(PADDLE_H);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SERVE_DELAY);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [3:0]       sl_q, sl_d, sr_q, sr_d;
    logic             tp_q, tp_d, tw_q, tw_d;
    logic             brst_q, brst_d;
    logic             lmiss_q, lmiss_d;

    logic             left_edge, right_edge, wall, in_pad, hit, miss;
    logic [Y_W-1:0]   pad_y;
    logic [Y_W:0]     pad_end;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       score_new;

    // The x >= SCREEN_W test catches a leftward step that wrapped below zero.
    assign left_edge  = (x_q <= LEFT_X) || (x_q >= X_LIMIT);
    assign right_edge = (x_q >= RIGHT_X) && (x_q < X_LIMIT);
    assign wall       = (y_q < WALL_LO) || (y_q > WALL_HI);
    assign pad_y      = left_edge ? paddle_l_y : paddle_r_y;
    assign pad_end    = {1'b0, pad_y} + PAD_SPAN;
    assign in_pad     = ({1'b0, y_q} >= {1'b0, pad_y}) && ({1'b0, y_q} < pad_end);
    assign hit        = (left_edge || right_edge) && in_pad;
    assign miss       = (left_edge || right_edge) && !in_pad;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign score_new  = sat_inc(lmiss_q ? sr_q : sl_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        tp_d    = 1'b0;
        tw_d    = 1'b0;
        lmiss_d = lmiss_q;
        case (state_q)
            S_IDLE: begin
                if (serve_btn) begin
                    state_d = S_SERVE;
                    cnt_d   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_END) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (frame_tick && !pause) state_d = S_CHECK;
            end
            S_CHECK: begin
                // A miss suppresses both pulses so the ball block is not disturbed.
                if (miss) begin
                    lmiss_d = left_edge;
                    state_d = S_POINT;
                end else begin
                    tp_d    = hit;
                    tw_d    = wall;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                x_d     = ball_new_x;
                y_d     = ball_new_y;
                state_d = S_PLAY;
            end
            S_POINT: begin
                if (lmiss_q) sr_d = score_new;
                else         sl_d = score_new;
                if (score_new == WIN) begin
                    state_d = S_OVER;
                end else begin
                    x_d     = CENTRE_X;
                    y_d     = CENTRE_Y;
                    cnt_d   = '0;
                    state_d = S_SERVE;
                end
            end
            S_OVER: begin
                if (serve_btn) begin
                    sl_d    = 4'd0;
                    sr_d    = 4'd0;
                    x_d     = CENTRE_X;
                    y_d     = CENTRE_Y;
                    cnt_d   = '0;
                    state_d = S_SERVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ball block is held in reset outside the active rally states, one cycle behind state.
    assign brst_d = !((state_q == S_PLAY) || (state_q == S_CHECK) ||
                      (state_q == S_SETTLE) || (state_q == S_CAPTURE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= CENTRE_X;
            y_q     <= CENTRE_Y;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            tp_q    <= 1'b0;
            tw_q    <= 1'b0;
            brst_q  <= 1'b1;
            lmiss_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            tp_q    <= tp_d;
            tw_q    <= tw_d;
            brst_q  <= brst_d;
            lmiss_q <= lmiss_d;
        end
    end

    assign ball_pos_x      = x_q;
    assign ball_pos_y      = y_q;
    assign ball_rst        = brst_q;
    assign touching_paddle = tp_q;
    assign touching_wall   = tw_q;
    assign score_l         = sl_q;
    assign score_r         = sr_q;
    assign game_over       = (state_q == S_OVER);

endmodule
